// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered driver for an 8-digit active-low seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  DIG_EN,
  input  logic        LOAD,
  output logic        PENDING,
  output logic        FRAME,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             frame_q, frame_d;
  logic             pend_flag_q, pend_flag_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic [7:0]       pend_en_q, pend_en_d;
  logic [31:0]      act_data_q, act_data_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic [7:0]       act_en_q, act_en_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nib;
  logic [7:0]       lz_mask;
  logic             lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 3'd7);

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    frame_d = boundary;
  end

  // A LOAD on the boundary bypasses the pending stage so it lands in the frame that starts now.
  always_comb begin
    pend_flag_d = pend_flag_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    if (boundary && LOAD) begin
      act_data_d  = DATA;
      act_dp_d    = DP_IN;
      act_en_d    = DIG_EN;
      pend_flag_d = 1'b0;
    end else if (boundary && pend_flag_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_en_d    = pend_en_q;
      pend_flag_d = 1'b0;
    end else if (LOAD) begin
      pend_data_d = DATA;
      pend_dp_d   = DP_IN;
      pend_en_d   = DIG_EN;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int n = 7; n >= 1; n--) begin
        zero_above = zero_above & (act_data_q[4*n +: 4] == 4'h0);
        lz_mask[n] = zero_above;
      end
    end
`endif
  end

  assign nib = act_data_q[{idx_q, 2'b00} +: 4];
  assign lit = (cnt_q >= BLANK_END) && act_en_q[idx_q] && !lz_mask[idx_q];

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = seg_decode(nib);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      pend_flag_q <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      pend_flag_q <= pend_flag_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN      = an_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign DP      = dp_q;
  assign PENDING = pend_flag_q;
  assign FRAME   = frame_q;

endmodule
